// File: rtl/mag_sqrt_sched_pkg.sv
// Shared types for the magnitude scheduler: FSM state encoding and power-word width helper.
package mag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    OUT    = 2'd3
  } mag_state_e;

  function automatic int pwr_w(input int iw);
    return 2 * iw;
  endfunction

endpackage

// File: rtl/mag_sqrt_sched_if.sv
// Bin input stream and magnitude output stream of mag_sqrt_sched.
// Both streams are valid/ready: a beat transfers on a rising edge with valid&ready high; once
// valid is raised the payload stays stable until that edge, and ready never waits on valid.
interface mag_sqrt_sched_if #(
  parameter int IW   = 16,
  parameter int IDXW = 10
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IW-1:0]   in_re;
  logic signed [IW-1:0]   in_im;
  logic        [IDXW-1:0] in_idx;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic        [IW-1:0]   out_mag;
  logic        [IDXW-1:0] out_idx;
  logic                   out_last;
  logic                   busy;

  modport master (
    output in_valid, in_re, in_im, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_mag, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_re, in_im, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_mag, out_idx, out_last, busy
  );
endinterface

// File: rtl/mag_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; the head word is visible on dout while non-empty.
module mag_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule

// File: rtl/sqrt_core.sv
// Shared iterative restoring square-root core: one result bit per cycle, busy_o high for DW/2 cycles
// after a din_valid_i pulse; sqrt_o/rem_o hold the last result while idle.
module sqrt_core #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din_i,
  input  logic            din_valid_i,
  output logic            busy_o,
  output logic [DW/2-1:0] sqrt_o,
  output logic [DW/2:0]   rem_o
);
  localparam int QW = DW / 2;
  localparam int CW = $clog2(QW + 1);

  logic [DW-1:0]   x_q;
  logic [QW+1:0]   r_q;
  logic [QW-1:0]   q_q;
  logic [CW-1:0]   cnt_q;
  logic [QW+1:0]   r_sh;
  logic [QW+1:0]   trial;

  // Before the final step the partial remainder fits QW bits, so the shift loses nothing.
  always_comb begin
    r_sh  = {r_q[QW-1:0], x_q[DW-1:DW-2]};
    trial = {q_q, 2'b01};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_o <= 1'b0;
    end else if (!busy_o) begin
      if (din_valid_i) begin
        x_q    <= din_i;
        r_q    <= '0;
        q_q    <= '0;
        cnt_q  <= CW'(QW);
        busy_o <= 1'b1;
      end
    end else begin
      x_q <= {x_q[DW-3:0], 2'b00};
      if (r_sh >= trial) begin
        r_q <= r_sh - trial;
        q_q <= {q_q[QW-2:0], 1'b1};
      end else begin
        r_q <= r_sh;
        q_q <= {q_q[QW-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_o <= 1'b0;
    end
  end

  assign sqrt_o = q_q;
  assign rem_o  = r_q[QW:0];
endmodule

// File: rtl/mag_sqrt_sched.sv
// Magnitude scheduler: squares each bin, queues power words, runs them one at a time through sqrt_core.
// Build option MAG_ROUND_EN: round |X| to nearest (saturating) instead of truncating.
module mag_sqrt_sched
  import mag_pkg::*;
#(
  parameter int IW         = 16,
  parameter int IDXW       = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mag_sqrt_sched_if.slave bus,
  output mag_state_e      dbg_state
);
  localparam int PW = pwr_w(IW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PW-1:0]   pwr;
    logic [IDXW-1:0] idx;
    logic            last;
  } entry_t;

  logic                 in_fire;
  logic signed [PW-1:0] re_sq;
  logic signed [PW-1:0] im_sq;
  logic                 s1_valid;
  entry_t               s1_entry;
  entry_t               head;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  mag_state_e           state;
  mag_state_e           state_next;
  logic                 din_valid;
  logic                 core_busy;
  logic [IW-1:0]        core_sqrt;
  logic [IW-1:0]        mag_next;
  logic [IDXW-1:0]      run_idx;
  logic                 run_last;
  logic [IW-1:0]        out_mag_q;
  logic [IDXW-1:0]      out_idx_q;
  logic                 out_last_q;
`ifdef MAG_ROUND_EN
  logic [IW:0]          core_rem;
`else
  logic [IW:0]          core_rem_unused;
`endif

  // Room is reserved for the word still in S1, so nothing accepted can overflow the FIFO.
  assign bus.in_ready = rst_n & ((fifo_count + CW'(s1_valid)) < CW'(FIFO_DEPTH));
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    re_sq = PW'(bus.in_re) * PW'(bus.in_re);
    im_sq = PW'(bus.in_im) * PW'(bus.in_im);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_entry.pwr  <= $unsigned(re_sq) + $unsigned(im_sq);
        s1_entry.idx  <= bus.in_idx;
        s1_entry.last <= bus.in_last;
      end
    end
  end

  mag_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .din   (s1_entry),
    .pop   (fifo_pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  sqrt_core #(
    .DW (PW)
  ) u_sqrt (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_i       (head.pwr),
    .din_valid_i (din_valid),
    .busy_o      (core_busy),
    .sqrt_o      (core_sqrt),
`ifdef MAG_ROUND_EN
    .rem_o       (core_rem)
`else
    .rem_o       (core_rem_unused)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (!core_busy) state_next = OUT;
      OUT:     if (bus.out_ready) state_next = fifo_empty ? IDLE : LAUNCH;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = (state == LAUNCH);
    din_valid = (state == LAUNCH);
  end

  // rem > root means the value sits at or above (root + 0.5)^2.
  always_comb begin
`ifdef MAG_ROUND_EN
    mag_next = core_sqrt;
    if ((core_rem > {1'b0, core_sqrt}) && !(&core_sqrt)) mag_next = core_sqrt + IW'(1);
`else
    mag_next = core_sqrt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_idx    <= '0;
      run_last   <= 1'b0;
      out_mag_q  <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        run_idx  <= head.idx;
        run_last <= head.last;
      end
      if (state == RUN && !core_busy) begin
        out_mag_q  <= mag_next;
        out_idx_q  <= run_idx;
        out_last_q <= run_last;
      end
    end
  end

  assign bus.out_valid = (state == OUT);
  assign bus.out_mag   = out_mag_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = s1_valid | !fifo_empty | (state != IDLE);
  assign dbg_state     = state;

  a_launch_idle_core: assert property (@(posedge clk) disable iff (!rst_n) !(din_valid && core_busy));
endmodule

// File: tb/tb_mag_sqrt_sched.sv
// Directed bench for mag_sqrt_sched: reset values, latency/throughput, extremes, back-pressure burst,
// mid-run reset and a random stall phase, all scored against an in-order expected queue.
module tb_mag_sqrt_sched;
  import mag_pkg::*;

  localparam int IW     = 16;
  localparam int IDXW   = 10;
  localparam int DEPTH  = 8;
  localparam int LAT    = IW + 4;
  localparam int PERIOD = IW + 3;
  localparam int SBW    = 1 + IDXW + IW;
  localparam int BUDGET = 1000;
`ifdef MAG_ROUND_EN
  localparam logic [IW-1:0] EXP_MAX = 16'd46341;
  localparam logic [IW-1:0] EXP_13  = 16'd4;
`else
  localparam logic [IW-1:0] EXP_MAX = 16'd46340;
  localparam logic [IW-1:0] EXP_13  = 16'd3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  mag_state_e dbg_state;

  mag_sqrt_sched_if #(.IW(IW), .IDXW(IDXW)) bus ();

  mag_sqrt_sched #(
    .IW         (IW),
    .IDXW       (IDXW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int               n_vec = 0;
  int               n_err = 0;
  int               n_acc = 0;
  int               hs_cyc = 0;
  logic [SBW-1:0]   exp_q[$];
  int               out_cycles[$];
  logic             prev_hold = 1'b0;
  logic [SBW-1:0]   prev_word = '0;
  logic [SBW-1:0]   cur_word;
  logic             rnd_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] ref_mag(input int re, input int im);
    longint p;
    longint q;
    longint t;
    p = longint'(re) * re + longint'(im) * im;
    q = 0;
    for (int b = IW - 1; b >= 0; b--) begin
      t = q | (longint'(1) << b);
      if (t * t <= p) q = t;
    end
`ifdef MAG_ROUND_EN
    if ((p - q * q > q) && (q != 65535)) q = q + 1;
`endif
    return q[IW-1:0];
  endfunction

  always_comb cur_word = {bus.out_last, bus.out_idx, bus.out_mag};

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", cur_word, prev_word);
      end
      if (bus.out_valid && bus.out_ready) begin
        out_cycles.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_out", cur_word, 0);
        else                   check("out_word", cur_word, exp_q.pop_front());
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_word = cur_word;
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_bin(input logic signed [IW-1:0] re, input logic signed [IW-1:0] im,
                          input logic [IDXW-1:0] idx, input logic last, input logic [IW-1:0] exp_mag);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    bus.in_idx   = idx;
    bus.in_last  = last;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        n_acc++;
        exp_q.push_back({last, idx, exp_mag});
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("in_handshake_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * BUDGET; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", ok, 1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic signed [IW-1:0] r_re;
    logic signed [IW-1:0] r_im;
    bit found;
    int base;

    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_idx    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rnd_done      = 1'b0;

    // Reset values
    idle_cycles(3);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_mag", bus.out_mag, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    check("post_rst_in_ready", bus.in_ready, 1);

    // 3-4-5 with end-to-end latency from the input handshake
    send_bin(16'sd3, 16'sd4, 10'd5, 1'b0, 16'd5);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("latency_seen", found, 1);
    check("latency_cycles", cyc - hs_cyc, LAT);
    drain();

    // Extremes and small hand-computed roots
    send_bin(-16'sd32768, -16'sd32768, 10'd1, 1'b0, EXP_MAX);
    send_bin(16'sd32767, 16'sd0, 10'd2, 1'b0, 16'd32767);
    send_bin(-16'sd1, -16'sd1, 10'd3, 1'b0, 16'd1);
    send_bin(16'sd2, 16'sd3, 10'd4, 1'b0, EXP_13);
    send_bin(16'sd10, -16'sd10, 10'd6, 1'b0, 16'd14);
    send_bin(16'sd0, 16'sd0, 10'd1023, 1'b1, 16'd0);
    drain();

    // Steady-state spacing with out_ready held high
    out_cycles.delete();
    send_bin(16'sd6, 16'sd8, 10'd20, 1'b0, 16'd10);
    send_bin(16'sd5, 16'sd12, 10'd21, 1'b0, 16'd13);
    send_bin(16'sd8, 16'sd15, 10'd22, 1'b1, 16'd17);
    drain();
    check("tput_count", out_cycles.size(), 3);
    if (out_cycles.size() == 3) begin
      check("tput_gap0", out_cycles[1] - out_cycles[0], PERIOD);
      check("tput_gap1", out_cycles[2] - out_cycles[1], PERIOD);
    end

    // Burst of 20 against a stalled output
    bus.out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          r_re = 16'(i * 100 - 700);
          r_im = 16'(i * 37);
          send_bin(r_re, r_im, 10'(100 + i), (i == 19), ref_mag(int'(r_re), int'(r_im)));
        end
      end
      begin
        repeat (60) @(negedge clk);
        check("burst_accepted", n_acc - base, 9);
        check("burst_in_ready", bus.in_ready, 0);
        check("burst_out_valid", bus.out_valid, 1);
        check("burst_head_idx", bus.out_idx, 100);
        check("burst_busy", bus.busy, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while the core is running
    send_bin(16'sd3, 16'sd4, 10'd55, 1'b0, 16'd5);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dbg_state == RUN) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_run", found, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_mag", bus.out_mag, 0);
    check("midrst_state", dbg_state, IDLE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(1);
    send_bin(16'sd6, 16'sd8, 10'd7, 1'b0, 16'd10);
    drain();
    idle_cycles(30);
    check("no_stale_busy", bus.busy, 0);

    // Random operands, gaps and output stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          r_re = 16'($urandom);
          r_im = 16'($urandom);
          send_bin(r_re, r_im, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                   ref_mag(int'(r_re), int'(r_im)));
          idle_cycles($urandom_range(0, 2));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
